// File: rtl/fft_twiddle_pkg.sv
// Shared Q-format constants, coefficient triple type and twiddle table builder
// for the 64-point FFT datapath.
package fft_twiddle_pkg;

  localparam int CW     = 16;
  localparam int FRAC   = CW - 2;
  localparam int TBL_N  = 64;

  typedef struct packed {
    logic signed [CW-1:0] cps;
    logic signed [CW-1:0] c;
    logic signed [CW-1:0] cms;
  } coef_t;

  typedef coef_t [TBL_N-1:0] coef_table_t;

  // round(cos(2*pi*r/64) * 2^14) for the first quadrant, r = 0..16
  function automatic int cos_quarter(input int r);
    int v;
    case (r)
      0:       v = 16384;
      1:       v = 16305;
      2:       v = 16069;
      3:       v = 15679;
      4:       v = 15137;
      5:       v = 14449;
      6:       v = 13623;
      7:       v = 12665;
      8:       v = 11585;
      9:       v = 10394;
      10:      v = 9102;
      11:      v = 7723;
      12:      v = 6270;
      13:      v = 4756;
      14:      v = 3196;
      15:      v = 1606;
      default: v = 0;
    endcase
    return v;
  endfunction

  // round(cos(2*pi*k/64) * 2^14) for any k >= 0, unfolded by quadrant symmetry
  function automatic int cos_q64(input int k);
    int m;
    int q;
    int r;
    int t;
    m = k % TBL_N;
    q = m / 16;
    r = m % 16;
    t = (q == 1 || q == 3) ? cos_quarter(16 - r) : cos_quarter(r);
    return (q == 1 || q == 2) ? -t : t;
  endfunction

  // Forward-transform table: C = cos, S = -sin, stored as (C+S, C, C-S)
  function automatic coef_table_t build_table(input int n);
    coef_table_t tbl;
    int step;
    int c;
    int s;
    tbl  = '0;
    step = TBL_N / n;
    for (int k = 0; k < n; k++) begin
      c = cos_q64(k * step);
      s = -cos_q64(k * step + 48);
      tbl[k].cps = CW'(c + s);
      tbl[k].c   = CW'(c);
      tbl[k].cms = CW'(c - s);
    end
    return tbl;
  endfunction

endpackage

// File: rtl/pipelined_twiddle_mult_lut.sv
// Combinational twiddle coefficient table; inverse mode conjugates W^k by
// swapping the C+S and C-S entries.
module twiddle_coef_lut
  import fft_twiddle_pkg::*;
#(
  parameter int N  = 64,
  parameter int IW = 6
) (
  input  logic [IW-1:0] tw_idx,
  input  logic          inv,
  output coef_t         coef
);

  localparam coef_table_t TABLE = build_table(N);

  coef_t entry;

  always_comb begin
    entry = TABLE[tw_idx];
    coef  = entry;
    if (inv) begin
      coef.cps = entry.cms;
      coef.cms = entry.cps;
    end
  end

endmodule

// File: rtl/pipelined_twiddle_mult.sv
// Three-stage runtime-indexed complex twiddle multiplier (3-multiplier form)
// with valid/ready flow control, rounding, saturation and a sticky overflow flag.
module pipelined_twiddle_mult
  import fft_twiddle_pkg::*;
#(
  parameter int W  = 16,
  parameter int N  = 64,
  parameter int IW = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic signed [W-1:0] REAL_IN,
  input  logic signed [W-1:0] IMAG_IN,
  input  logic [IW-1:0]       TW_IDX,
  input  logic                INV,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic signed [W-1:0] REAL_OUT,
  output logic signed [W-1:0] IMAG_OUT,
  output logic                OVF,
  input  logic                CLR_OVF
);

  localparam int PW   = W + CW + 1;
  localparam int SW   = PW + 1;
  localparam int RND  = 1 << (FRAC - 1);
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  // Returns {saturated, value}: round half up, then clamp to W-bit signed.
  function automatic logic [W:0] round_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    logic [W:0]           res;
    r = (s + SW'(RND)) >>> FRAC;
    if (r > SW'(MAXV))      res = {1'b1, W'(MAXV)};
    else if (r < SW'(MINV)) res = {1'b1, W'(MINV)};
    else                    res = {1'b0, r[W-1:0]};
    return res;
  endfunction

  coef_t lut_coef;

  twiddle_coef_lut #(.N(N), .IW(IW)) u_lut (
    .tw_idx (TW_IDX),
    .inv    (INV),
    .coef   (lut_coef)
  );

  logic                 en;
  logic                 v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
  logic signed [W-1:0]  ar_q, ar_d, ai_q, ai_d;
  logic signed [W:0]    d_q, d_d;
  coef_t                coef_q, coef_d;
  logic signed [PW-1:0] p_cms_ai_q, p_cms_ai_d, p_c_d_q, p_c_d_d, p_cps_ar_q, p_cps_ar_d;
  logic signed [W-1:0]  real_q, real_d, imag_q, imag_d;
  logic                 ovf_q, ovf_d;
  logic signed [SW-1:0] re_sum, im_sum;
  logic [W:0]           re_rs, im_rs;

  assign en = ~out_valid_q | OUT_READY;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    v1_d        = v1_q;
    ar_d        = ar_q;
    ai_d        = ai_q;
    d_d         = d_q;
    coef_d      = coef_q;
    v2_d        = v2_q;
    p_cms_ai_d  = p_cms_ai_q;
    p_c_d_d     = p_c_d_q;
    p_cps_ar_d  = p_cps_ar_q;
    out_valid_d = out_valid_q;
    real_d      = real_q;
    imag_d      = imag_q;

    re_sum = SW'(p_cms_ai_q) + SW'(p_c_d_q);
    im_sum = SW'(p_cps_ar_q) - SW'(p_c_d_q);
    re_rs  = round_sat(re_sum);
    im_rs  = round_sat(im_sum);

    if (en) begin
      v1_d        = IN_VALID;
      ar_d        = REAL_IN;
      ai_d        = IMAG_IN;
      d_d         = (W+1)'(REAL_IN) - (W+1)'(IMAG_IN);
      coef_d      = lut_coef;
      v2_d        = v1_q;
      p_cms_ai_d  = PW'($signed(coef_q.cms)) * PW'(ai_q);
      p_c_d_d     = PW'($signed(coef_q.c)) * PW'(d_q);
      p_cps_ar_d  = PW'($signed(coef_q.cps)) * PW'(ar_q);
      out_valid_d = v2_q;
      real_d      = re_rs[W-1:0];
      imag_d      = im_rs[W-1:0];
    end

    // A new saturation wins over a simultaneous clear.
    ovf_d = (ovf_q & ~CLR_OVF) | (en & v2_q & (re_rs[W] | im_rs[W]));
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: data registers are cleared along with the valids; the pipe is shallow and this keeps outputs defined.
      v1_q        <= 1'b0;
      ar_q        <= '0;
      ai_q        <= '0;
      d_q         <= '0;
      coef_q      <= '0;
      v2_q        <= 1'b0;
      p_cms_ai_q  <= '0;
      p_c_d_q     <= '0;
      p_cps_ar_q  <= '0;
      out_valid_q <= 1'b0;
      real_q      <= '0;
      imag_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      ar_q        <= ar_d;
      ai_q        <= ai_d;
      d_q         <= d_d;
      coef_q      <= coef_d;
      v2_q        <= v2_d;
      p_cms_ai_q  <= p_cms_ai_d;
      p_c_d_q     <= p_c_d_d;
      p_cps_ar_q  <= p_cps_ar_d;
      out_valid_q <= out_valid_d;
      real_q      <= real_d;
      imag_q      <= imag_d;
      ovf_q       <= ovf_d;
    end
  end

  assign IN_READY  = en;
  assign OUT_VALID = out_valid_q;
  assign REAL_OUT  = real_q;
  assign IMAG_OUT  = imag_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_pipelined_twiddle_mult.sv
// Directed bench for pipelined_twiddle_mult: hand-computed twiddle products,
// saturation/OVF, stall behaviour and mid-stream reset.
module tb_pipelined_twiddle_mult;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] real_in;
  logic signed [15:0] imag_in;
  logic [5:0]         tw_idx;
  logic               inv_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] real_out;
  logic signed [15:0] imag_out;
  logic               ovf;
  logic               clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_twiddle_mult #(.W(16), .N(64), .IW(6)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .REAL_IN   (real_in),
    .IMAG_IN   (imag_in),
    .TW_IDX    (tw_idx),
    .INV       (inv_in),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .REAL_OUT  (real_out),
    .IMAG_OUT  (imag_out),
    .OVF       (ovf),
    .CLR_OVF   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One isolated sample: not visible after two edges, visible after the third.
  task automatic run_one(input string tag, input logic signed [15:0] ar, input logic signed [15:0] ai,
                         input logic [5:0] k, input logic inv, input int er, input int ei);
    real_in  = ar;
    imag_in  = ai;
    tw_idx   = k;
    inv_in   = inv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check({tag, " early valid"}, out_valid, 0);
    tick();
    check({tag, " valid"}, out_valid, 1);
    check({tag, " real"}, real_out, er);
    check({tag, " imag"}, imag_out, ei);
  endtask

  logic signed [15:0] s_ar [8];
  logic signed [15:0] s_ai [8];
  logic [5:0]         s_k  [8];
  int                 e_r  [8];
  int                 e_i  [8];
  int                 sent;
  int                 got;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    real_in   = '0;
    imag_in   = '0;
    tw_idx    = '0;
    inv_in    = 1'b0;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    repeat (3) tick();
    check("reset out_valid", out_valid, 0);
    check("reset ovf", ovf, 0);
    check("reset real_out", real_out, 0);
    check("reset imag_out", imag_out, 0);
    check("reset in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    run_one("k0", 1000, -2000, 6'd0, 1'b0, 1000, -2000);
    check("k0 ovf", ovf, 0);
    run_one("k0 inv", 1000, -2000, 6'd0, 1'b1, 1000, -2000);
    run_one("k16", 1000, -2000, 6'd16, 1'b0, -2000, -1000);
    run_one("k16 inv", 1000, -2000, 6'd16, 1'b1, 2000, 1000);
    run_one("k8 round", 1000, 0, 6'd8, 1'b0, 707, -707);
    run_one("k8 inv round", 1000, 0, 6'd8, 1'b1, 707, 707);
    run_one("k32", 123, -456, 6'd32, 1'b0, -123, 456);
    run_one("k48", 123, -456, 6'd48, 1'b0, 456, 123);
    check("pre-sat ovf", ovf, 0);

    run_one("k8 sat", 32767, -32768, 6'd8, 1'b0, -1, -32768);
    check("sat ovf set", ovf, 1);
    repeat (3) tick();
    check("sat ovf sticky", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf cleared", ovf, 0);

    // Back-to-back stream, alternating k=0 (identity) and k=16 (multiply by -j).
    for (int i = 0; i < 8; i++) begin
      s_ar[i] = 16'(100 * i + 11);
      s_ai[i] = 16'(-(100 * i + 22));
      s_k[i]  = (i % 2 == 1) ? 6'd16 : 6'd0;
      e_r[i]  = (i % 2 == 1) ? int'(s_ai[i]) : int'(s_ar[i]);
      e_i[i]  = (i % 2 == 1) ? -int'(s_ar[i]) : int'(s_ai[i]);
    end
    sent = 0;
    got  = 0;
    inv_in = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 10);
      if (sent < 8) begin
        in_valid = 1'b1;
        real_in  = s_ar[sent];
        imag_in  = s_ai[sent];
        tw_idx   = s_k[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 5) begin
        check("stall start out_valid", out_valid, 1);
        check("stall start in_ready", in_ready, 0);
      end
      if (cyc > 5 && cyc < 10) begin
        check("stall hold valid", out_valid, 1);
        check("stall hold real", real_out, e_r[got]);
        check("stall hold imag", imag_out, e_i[got]);
      end
      if (out_valid && out_ready) begin
        check("stream real", real_out, e_r[got]);
        check("stream imag", imag_out, e_i[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream count", got, 8);
    check("stream drained", out_valid, 0);
    tick();
    check("stream no extra", out_valid, 0);
    check("stream ovf", ovf, 0);

    // Three samples in flight, then a one-cycle reset.
    real_in = 32767; imag_in = -32768; tw_idx = 6'd8; in_valid = 1'b1;
    tick();
    real_in = 1; imag_in = 2; tw_idx = 6'd0;
    tick();
    real_in = 3; imag_in = 4;
    tick();
    in_valid = 1'b0;
    check("inflight out_valid", out_valid, 1);
    check("inflight ovf", ovf, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid reset out_valid", out_valid, 0);
    check("mid reset ovf", ovf, 0);
    check("mid reset real", real_out, 0);
    tick();
    check("flushed 1", out_valid, 0);
    tick();
    check("flushed 2", out_valid, 0);
    run_one("post-reset", 7, -9, 6'd0, 1'b0, 7, -9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_twiddle_mult.md
Name: pipelined_twiddle_mult

Overview:
Runtime-indexed, pipelined complex twiddle multiplier for the 64-point FFT datapath. It generalises the fixed-constant 3-multiplier complex multiplier to parametrised width and FFT size. The twiddle is selected per sample from an internal table, an inverse (conjugate) mode is provided, and valid/ready flow control allows placement between butterfly stages.

Parameters:
W, 16, signed data width of input and output real/imag
CW, 16, signed coefficient width; coefficients in Q2.(CW-2)
FRAC, 14, coefficient fractional bits (FRAC = CW-2)
N, 64, FFT size; table holds k = 0..N-1
IW, 6, twiddle index width, log2(N)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
IN_VALID  in  1  input sample valid
IN_READY  out  1  block accepts input this cycle
REAL_IN  in  W  input real, signed
IMAG_IN  in  W  input imag, signed
TW_IDX  in  IW  twiddle index k
INV  in  1  1 = multiply by conj(W^k) (IFFT)
OUT_VALID  out  1  output sample valid
OUT_READY  in  1  downstream accepts output
REAL_OUT  out  W  result real, signed
IMAG_OUT  out  W  result imag, signed
OVF  out  1  sticky saturation flag
CLR_OVF  in  1  clears OVF

Behaviour:
- Coefficients: C = round(cos(2πk/N)·2^FRAC); S = round(-sin(2πk/N)·2^FRAC); INV negates S. The table stores CpS = C+S, Cc = C, CmS = C-S. INV swaps CpS and CmS.
- Math: D = Ar - Ai (W+1 bits).
  - Real = CmS·Ai + C·D = C·Ar - S·Ai.
  - Imag = CpS·Ar - C·D = S·Ar + C·Ai.
  - Products are full width (W+CW+1); sums carry 1 extra bit.
- Scaling: add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up). Saturate to W-bit signed range [-2^(W-1), 2^(W-1)-1].
- Pipeline, latency 3 cycles from input accept to OUT_VALID:
  - S1 registers Ar, Ai, D and the three looked-up coefficients.
  - S2 registers the three products.
  - S3 registers the rounded/saturated outputs.
- Handshake:
  - Global advance enable EN = ~OUT_VALID | OUT_READY.
  - IN_READY = EN, combinational.
  - A sample is accepted when IN_VALID & IN_READY.
  - Each stage valid bit shifts only when EN=1; a bubble inserts valid=0.
  - While EN=0, all stage registers and outputs hold (data stable under stall).
- OVF:
  - Set on the cycle S3 loads a saturated result in either component.
  - Stays set until CLR_OVF=1 or RST.
  - If CLR_OVF and a new saturation coincide, OVF stays 1 (set wins).
- Index wrap: TW_IDX uses all IW bits; k=N/2..N-1 are valid table entries (no masking).
- Reset:
  - On RST=1, all stage valid bits, OUT_VALID and OVF become 0 at the next edge.
  - REAL_OUT and IMAG_OUT reset to 0. Data registers may also clear.
  - Reset mid-stream discards in-flight samples. No output appears until 3 cycles after the first post-reset accept.
- k=0 with INV=0 or 1 is exact: C=2^FRAC, S=0, so the output equals the input.

Decomposition:
- Package fft_twiddle_pkg holds:
  - Q-format constants (FRAC, CW).
  - A constant function computing the C/S/C+S/C-S table for N.
  - A coefficient triple typedef (cps, c, cms).
- Sub-module twiddle_coef_lut: combinational table indexed by TW_IDX, applies the INV swap, outputs CpS/C/CmS to S1.
- Multipliers and adders are behavioural, in the top module.

Test Plan:
- W=16, N=64, k=0, in (1000,-2000), OUT_READY=1 -> after 3 cycles out (1000,-2000), OVF=0.
- k=16 (W^16 = -j), in (1000,-2000) -> out (-2000,-1000).
- Same k=16 with INV=1 (+j) -> out (2000,1000).
- k=8, in (32767,-32768) -> REAL_OUT=-1, IMAG_OUT=-32768 (saturated), OVF=1. OVF holds 1 until CLR_OVF pulse, then 0.
- Stream 8 samples back-to-back, drop OUT_READY for 5 cycles mid-stream:
  - IN_READY falls the same cycle OUT_READY falls while OUT_VALID=1.
  - Outputs hold stable during the stall.
  - All 8 results emerge in order with no loss or duplication.
- Assert RST for 1 cycle with 3 samples in flight -> OUT_VALID=0 and OVF=0 the next cycle. The next accepted sample appears exactly 3 cycles later.
